// File: rtl/packet_parser_pkg.sv
// packet_parser_pkg: shared states, constants and ECC/CRC helpers for the packet parser
package packet_parser_pkg;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, DECODE_CHK, DONE} state_e;

   localparam logic [7:0] CRC_POLY = 8'h07;
   localparam logic [7:0] CRC_INIT = 8'h00;
   localparam int         TYPE_LSB = 0;
   localparam int         CNT_LSB  = 4;
   localparam int         ECC_LSB  = 4;
   localparam logic [3:0] SYN_MAX  = 4'd12;

   // Bit p-1 of the codeword is Hamming position p.
   function automatic logic [11:0] hamming_codeword(input logic [7:0] d, input logic [3:0] e);
      return {d[7:4], e[3], d[3:1], e[2], d[0], e[1], e[0]};
   endfunction

   function automatic logic [7:0] hamming_data(input logic [11:0] cw);
      return {cw[11:8], cw[6:4], cw[2]};
   endfunction

   function automatic logic [3:0] hamming_syndrome(input logic [11:0] cw);
      logic [3:0] s;
      s = '0;
      for (int p = 1; p <= 12; p++)
         if (cw[p-1]) s ^= 4'(p);
      return s;
   endfunction

   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++)
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
      return c;
   endfunction

endpackage

// File: rtl/packet_parser_if.sv
// packet_parser_if: control, status and memory-port signals of the packet parser
interface packet_parser_if;
   logic        start;
   logic [31:0] addr_hdr;
   logic        ignore_ecc_err;
   logic        mem_en;
   logic [13:0] mem_addr;
   logic [31:0] mem_data;
   logic        busy;
   logic        irq;
   logic        pkt_ecc_corr;
   logic        pkt_ecc_uncorr;
   logic        pkt_crc_err;
   logic [3:0]  pkt_byte_cnt;
   logic [3:0]  pkt_type;

   modport master (
      output start, addr_hdr, ignore_ecc_err, mem_data,
      input  mem_en, mem_addr, busy, irq, pkt_ecc_corr, pkt_ecc_uncorr, pkt_crc_err,
             pkt_byte_cnt, pkt_type
   );

   modport slave (
      input  start, addr_hdr, ignore_ecc_err, mem_data,
      output mem_en, mem_addr, busy, irq, pkt_ecc_corr, pkt_ecc_uncorr, pkt_crc_err,
             pkt_byte_cnt, pkt_type
   );
endinterface

// File: rtl/packet_parser_byte_reader.sv
// mem_byte_reader: maps a byte address onto the word port and returns the addressed lane one cycle later
module mem_byte_reader (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic [15:0] byte_addr_i,
   input  logic [31:0] mem_data_i,
   output logic        mem_en_o,
   output logic [13:0] mem_addr_o,
   output logic [7:0]  byte_o
);
   logic [13:0] addr_q;
   logic [1:0]  lane_q;

   assign mem_en_o   = req_i;
   assign mem_addr_o = req_i ? byte_addr_i[15:2] : addr_q;
   assign byte_o     = mem_data_i[{lane_q, 3'b000} +: 8];

   // remember the issued word address (held while idle) and the lane to pick from the returning word
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         lane_q <= '0;
      end else if (req_i) begin
         addr_q <= byte_addr_i[15:2];
         lane_q <= byte_addr_i[1:0];
      end
   end
endmodule

// File: rtl/packet_parser.sv
// packet_parser: reads a packet byte by byte, ECC-corrects the header and checks the CRC
module packet_parser
   import packet_parser_pkg::*;
(
   input logic            clk,
   input logic            reset,
   packet_parser_if.slave bus
);
   state_e      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [4:0]  idx_q, idx_d;
   logic [7:0]  b0_q, b0_d, crc_q, crc_d;
   logic [3:0]  cnt_q, cnt_d, type_q, type_d;
   logic        corr_q, corr_d, uncorr_q, uncorr_d, crc_err_q, crc_err_d, ign_q, ign_d;
   logic [7:0]  rd_byte, fixed_b0;
   logic [11:0] cw;
   logic [3:0]  syn;
   logic        fixable, bad, last, unused_addr;

   assign unused_addr = ^bus.addr_hdr[31:16];
   assign cw          = hamming_codeword(b0_q, rd_byte[ECC_LSB +: 4]);
   assign syn         = hamming_syndrome(cw);
   assign bad         = syn > SYN_MAX;
   assign fixable     = syn != 4'd0 && !bad;
   assign fixed_b0    = fixable ? hamming_data(cw ^ (12'd1 << (syn - 4'd1))) : b0_q;
   assign last        = idx_q == {1'b0, cnt_q} + 5'd3;

   mem_byte_reader u_reader (
      .clk         (clk),
      .reset       (reset),
      .req_i       (state_q == RD_REQ),
      .byte_addr_i (addr_q),
      .mem_data_i  (bus.mem_data),
      .mem_en_o    (bus.mem_en),
      .mem_addr_o  (bus.mem_addr),
      .byte_o      (rd_byte)
   );

   // FSM state, byte cursor, running CRC and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         idx_q     <= '0;
         b0_q      <= '0;
         crc_q     <= CRC_INIT;
         cnt_q     <= '0;
         type_q    <= '0;
         corr_q    <= 1'b0;
         uncorr_q  <= 1'b0;
         crc_err_q <= 1'b0;
         ign_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         idx_q     <= idx_d;
         b0_q      <= b0_d;
         crc_q     <= crc_d;
         cnt_q     <= cnt_d;
         type_q    <= type_d;
         corr_q    <= corr_d;
         uncorr_q  <= uncorr_d;
         crc_err_q <= crc_err_d;
         ign_q     <= ign_d;
      end
   end

   // alternate request/data cycles per byte; B1 arrives in DECODE_CHK where the header is resolved
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      idx_d     = idx_q;
      b0_d      = b0_q;
      crc_d     = crc_q;
      cnt_d     = cnt_q;
      type_d    = type_q;
      corr_d    = corr_q;
      uncorr_d  = uncorr_q;
      crc_err_d = crc_err_q;
      ign_d     = ign_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d   = RD_REQ;
            addr_d    = bus.addr_hdr[15:0];
            idx_d     = '0;
            crc_d     = CRC_INIT;
            cnt_d     = '0;
            type_d    = '0;
            corr_d    = 1'b0;
            uncorr_d  = 1'b0;
            crc_err_d = 1'b0;
            ign_d     = bus.ignore_ecc_err;
         end
         RD_REQ: state_d = idx_q == 5'd1 ? DECODE_CHK : RD_DATA;
         DECODE_CHK: begin
            type_d   = fixed_b0[TYPE_LSB +: 4];
            cnt_d    = fixed_b0[CNT_LSB +: 4];
            corr_d   = fixable;
            uncorr_d = bad;
            crc_d    = crc8_byte(CRC_INIT, fixed_b0);
            idx_d    = idx_q + 5'd1;
            addr_d   = addr_q + 16'd1;
            state_d  = bad && !ign_q ? DONE : RD_REQ;
         end
         RD_DATA: begin
            idx_d   = idx_q + 5'd1;
            addr_d  = addr_q + 16'd1;
            state_d = idx_q != 5'd0 && last ? DONE : RD_REQ;
            if (idx_q == 5'd0) b0_d = rd_byte;
            else if (last) crc_err_d = crc_q != rd_byte;
            else crc_d = crc8_byte(crc_q, rd_byte);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy           = state_q != IDLE;
   assign bus.irq            = state_q == DONE;
   assign bus.pkt_ecc_corr   = corr_q;
   assign bus.pkt_ecc_uncorr = uncorr_q;
   assign bus.pkt_crc_err    = crc_err_q;
   assign bus.pkt_byte_cnt   = cnt_q;
   assign bus.pkt_type       = type_q;
endmodule

// File: tb/tb_packet_parser.sv
// tb_packet_parser: directed table, corner sequences and randomized packets against a reference model
module tb_packet_parser;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   packet_parser_if bus();
   packet_parser dut (.clk(clk), .reset(reset), .bus(bus));

   int          errors = 0;
   int          checks = 0;
   logic [13:0] last_addr = '0;
   logic [7:0]  mem_b [0:65535];
   int          dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

   typedef struct {
      logic        ign;
      logic [7:0]  b0, b1, b2, b3;
      int          irq_c;
      logic [10:0] flags;
   } vec_t;
   vec_t tab [6];

   always @(posedge clk)
      if (bus.mem_en)
         bus.mem_data <= {mem_b[{bus.mem_addr, 2'd3}], mem_b[{bus.mem_addr, 2'd2}],
                          mem_b[{bus.mem_addr, 2'd1}], mem_b[{bus.mem_addr, 2'd0}]};

   function automatic logic [16:0] obs();
      return {bus.busy, bus.irq, bus.mem_en, bus.mem_addr};
   endfunction

   function automatic logic [10:0] flags();
      return {bus.pkt_ecc_corr, bus.pkt_ecc_uncorr, bus.pkt_crc_err, bus.pkt_byte_cnt, bus.pkt_type};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
      int r;
      r = int'(c ^ d);
      for (int i = 0; i < 8; i++) r = (r & 128) != 0 ? ((r << 1) ^ 7) & 255 : (r << 1) & 255;
      return r[7:0];
   endfunction

   // expected {corr, uncorr, crc_err, cnt, type} of the packet stored at a
   function automatic logic [10:0] model(input logic [15:0] a, input logic ign,
                                         output int irq_c, output logic [7:0] crc_c);
      logic [7:0] b0, b1, d;
      logic       corr, unc;
      int         syn, n;
      b0  = mem_b[a];
      b1  = mem_b[a + 16'd1];
      syn = 0;
      for (int i = 0; i < 8; i++) if (b0[i]) syn ^= dpos[i];
      for (int j = 0; j < 4; j++) if (b1[4+j]) syn ^= 1 << j;
      corr = syn >= 1 && syn <= 12;
      unc  = syn > 12;
      d    = b0;
      for (int i = 0; i < 8; i++) if (corr && dpos[i] == syn) d[i] = ~d[i];
      n     = int'(d[7:4]) + 4;
      crc_c = crc_ref(8'h00, d);
      for (int k = 2; k < n - 1; k++) crc_c = crc_ref(crc_c, mem_b[a + 16'(k)]);
      if (unc && !ign) begin
         irq_c = 5;
         return {3'b010, d};
      end
      irq_c = 2 * n + 1;
      return {corr, unc, crc_c != mem_b[a + 16'(n - 1)], d};
   endfunction

   // launch a task (caller is at a negedge) and check every cycle until one past irq
   task automatic run(input logic [31:0] base, input logic ign, input int irq_c,
                      input logic [10:0] ef, input int extra_c, input int rst_c);
      int          nr;
      logic        rd;
      logic [15:0] ba;
      nr = (irq_c - 1) / 2;
      bus.addr_hdr       = base;
      bus.ignore_ecc_err = ign;
      bus.start          = 1'b1;
      for (int c = 1; c <= irq_c + 1; c++) begin
         @(negedge clk);
         bus.start = (c == extra_c);
         rd = (c % 2 == 1) && (c <= 2 * nr - 1);
         ba = base[15:0] + 16'((c - 1) / 2);
         if (rd) last_addr = ba[15:2];
         chk("ctl", obs(), {c <= irq_c, c == irq_c, rd, last_addr});
         if (c == 1) chk("clear", flags(), 0);
         if (c >= irq_c) chk("result", flags(), ef);
         if (c == rst_c) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            last_addr = '0;
            for (int j = 0; j < 6; j++) begin
               chk("mid_reset", {obs(), flags()}, 0);
               @(negedge clk);
            end
            return;
         end
      end
   endtask

   task automatic put4(input logic [15:0] a, input logic [7:0] b0, b1, b2, b3);
      mem_b[a]         = b0;
      mem_b[a + 16'd1] = b1;
      mem_b[a + 16'd2] = b2;
      mem_b[a + 16'd3] = b3;
   endtask

   initial begin
      int          irq_c, e, mode, r;
      logic [7:0]  crc_c, b0, b1;
      logic [10:0] f;
      logic [31:0] a;
      bus.start = 1'b1;
      bus.addr_hdr = '0;
      bus.ignore_ecc_err = 1'b0;
      for (int i = 0; i < 65536; i++) mem_b[i] = 8'($urandom);
      tab[0] = '{1'b0, 8'h00, 8'h00, 8'hAB, 8'h58, 9, 11'h000};
      tab[1] = '{1'b0, 8'h00, 8'h00, 8'hAA, 8'h58, 9, 11'h100};
      tab[2] = '{1'b0, 8'h01, 8'h00, 8'hAB, 8'h58, 9, 11'h400};
      tab[3] = '{1'b0, 8'h02, 8'h80, 8'hAB, 8'h58, 5, 11'h202};
      tab[4] = '{1'b1, 8'h02, 8'h80, 8'hAB, 8'h72, 9, 11'h202};
      tab[5] = '{1'b0, 8'h00, 8'h10, 8'hAB, 8'h58, 9, 11'h400};
      repeat (3) @(negedge clk);
      chk("reset_state", {obs(), flags()}, 0);
      reset = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      chk("start_with_reset", obs(), 0);
      for (int i = 0; i < 6; i++) begin
         put4(16'h0000, tab[i].b0, tab[i].b1, tab[i].b2, tab[i].b3);
         run(32'h0, tab[i].ign, tab[i].irq_c, tab[i].flags, 0, 0);
      end
      put4(16'hFFFE, 8'h00, 8'h00, 8'hAB, 8'h58);
      run(32'h1234_FFFE, 1'b0, 9, 11'h000, 0, 0);
      mem_b[3] = 8'h70;
      mem_b[4] = 8'h80;
      for (int k = 5; k < 13; k++) mem_b[k] = 8'($urandom);
      f = model(16'd3, 1'b0, irq_c, crc_c);
      mem_b[13] = crc_c;
      run(32'h3, 1'b0, 23, 11'h070, 10, 0);
      put4(16'h0000, 8'h00, 8'h00, 8'hAB, 8'h58);
      run(32'h0, 1'b0, 9, 11'h000, 0, 6);
      run(32'h0, 1'b0, 9, 11'h000, 0, 0);
      for (int t = 0; t < 30; t++) begin
         a    = $urandom;
         b0   = 8'($urandom);
         mode = $urandom_range(0, 2);
         e    = 0;
         for (int i = 0; i < 8; i++) if (b0[i]) e ^= dpos[i];
         b1 = {4'(e), 4'($urandom)};
         if (mode == 1) b1 = 8'($urandom);
         if (mode == 2) begin
            r = $urandom_range(0, 11);
            if (r < 8) b0[r] = ~b0[r];
            else b1[r - 4] = ~b1[r - 4];
         end
         mem_b[a[15:0]]         = b0;
         mem_b[a[15:0] + 16'd1] = b1;
         for (int k = 2; k < 20; k++) mem_b[a[15:0] + 16'(k)] = 8'($urandom);
         f = model(a[15:0], 1'($urandom), irq_c, crc_c);
         if ($urandom_range(0, 3) != 0) mem_b[a[15:0] + 16'(int'(f[7:4]) + 3)] = crc_c;
         mode = $urandom_range(0, 1);
         f = model(a[15:0], 1'(mode), irq_c, crc_c);
         run(a, 1'(mode), irq_c, f, 0, 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
